// File: rtl/uart_rx_if.sv
// Receive-side bundle of the UART link: serial line in, recovered byte plus status out.
// The receiver uses the slave view; the bench/consumer drives the line through the master view.
interface uart_rx_if;
    logic       rx_serial;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_parity_err;
    logic       rx_frame_err;
    logic       rx_busy;

    modport master (
        output rx_serial,
        input  rx_data,
        input  rx_valid,
        input  rx_parity_err,
        input  rx_frame_err,
        input  rx_busy
    );

    modport slave (
        input  rx_serial,
        output rx_data,
        output rx_valid,
        output rx_parity_err,
        output rx_frame_err,
        output rx_busy
    );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver for 8E1 frames.
// Samples each bit once at its centre and reports parity/framing errors with each byte.
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic      rx_clk,
    input  logic      reset,
    uart_rx_if.slave  bus
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             par_err_pend;

    logic             sync1;
    logic             sync2;
    logic             prev;

    logic [7:0]       rx_data_q;
    logic             rx_valid_q;
    logic             rx_parity_err_q;
    logic             rx_frame_err_q;
    logic             rx_busy_q;

    // START waits half a bit to land on the centre; later states wait a full bit from there.
    always_ff @(posedge rx_clk) begin
        if (reset) begin
            sync1           <= 1'b1;
            sync2           <= 1'b1;
            prev            <= 1'b1;
            state           <= IDLE;
            cnt             <= '0;
            bit_idx         <= 3'd0;
            shift           <= 8'h00;
            par_err_pend    <= 1'b0;
            rx_data_q       <= 8'h00;
            rx_valid_q      <= 1'b0;
            rx_parity_err_q <= 1'b0;
            rx_frame_err_q  <= 1'b0;
            rx_busy_q       <= 1'b0;
        end else begin
            sync1      <= bus.rx_serial;
            sync2      <= sync1;
            prev       <= sync2;
            rx_valid_q <= 1'b0;

            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= 3'd0;
                    if (!sync2 && prev) begin
                        state     <= START;
                        rx_busy_q <= 1'b1;
                    end
                end

                START: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        if (!sync2) begin
                            state <= DATA;
                        end else begin
                            state     <= IDLE;
                            rx_busy_q <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        shift <= {sync2, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            bit_idx <= 3'd0;
                            state   <= PARITY;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                PARITY: begin
                    if (cnt == FULL_M1) begin
                        cnt          <= '0;
                        par_err_pend <= sync2 ^ (^shift);
                        state        <= STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                // Leaving at mid-stop lets a start bit follow with no idle gap.
                STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt             <= '0;
                        rx_data_q       <= shift;
                        rx_parity_err_q <= par_err_pend;
                        rx_frame_err_q  <= ~sync2;
                        rx_valid_q      <= 1'b1;
                        rx_busy_q       <= 1'b0;
                        state           <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state     <= IDLE;
                    rx_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_data       = rx_data_q;
    assign bus.rx_valid      = rx_valid_q;
    assign bus.rx_parity_err = rx_parity_err_q;
    assign bus.rx_frame_err  = rx_frame_err_q;
    assign bus.rx_busy       = rx_busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at OVERSAMPLE = 16: frames are driven bit-by-bit and each
// expected delivery (byte, flags, exact valid cycle) is queued and checked when rx_valid fires.
module tb_uart_rx;

    localparam int OS = 16;

    logic rx_clk;
    logic reset;
    int   cyc;
    int   checks;
    int   failures;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         vcyc;
    } exp_t;

    exp_t exp_q[$];
    logic busy_hist[int];

    uart_rx_if bus();

    uart_rx #(.OVERSAMPLE(OS)) dut (
        .rx_clk (rx_clk),
        .reset  (reset),
        .bus    (bus)
    );

    initial rx_clk = 1'b0;
    always #5 rx_clk = ~rx_clk;

    initial cyc = 0;
    always @(posedge rx_clk) cyc <= cyc + 1;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Scoreboard side: every valid strobe must match the oldest queued frame, at its predicted cycle.
    always @(negedge rx_clk) begin
        busy_hist[cyc] = bus.rx_busy;
        if (bus.rx_valid === 1'b1) begin
            check_output("valid_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check_output("rx_data", 32'(bus.rx_data), 32'(e.data));
                check_output("rx_parity_err", 32'(bus.rx_parity_err), 32'(e.perr));
                check_output("rx_frame_err", 32'(bus.rx_frame_err), 32'(e.ferr));
                check_output("valid_cycle", 32'(cyc), 32'(e.vcyc));
            end
        end
    end

    // Caller must be 1ns past a rising edge; the task leaves the line at the stop level.
    task automatic apply_stimulus(input logic [7:0] data, input bit flip_par, input logic stop_bit,
                                  input int abort_bit, input bit expect_frame, output int start_cyc);
        logic [10:0] bits;
        start_cyc = cyc;
        bits = {stop_bit, (^data) ^ flip_par, data, 1'b0};
        if (expect_frame)
            exp_q.push_back('{data, logic'(flip_par), ~stop_bit, start_cyc + 10 * OS + OS / 2 + 3});
        for (int k = 0; k < 11; k++) begin
            bus.rx_serial = bits[k];
            if (k == abort_bit) begin
                repeat (6) @(posedge rx_clk);
                #1;
                reset = 1'b1;
                @(posedge rx_clk);
                #1;
                reset = 1'b0;
                bus.rx_serial = 1'b1;
                return;
            end
            repeat (OS) @(posedge rx_clk);
            #1;
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge rx_clk);
        #1;
    endtask

    initial begin
        int n;
        int n2;
        int busy_ones;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.rx_serial = 1'b1;

        repeat (3) @(posedge rx_clk);
        @(negedge rx_clk);
        check_output("reset_rx_data", 32'(bus.rx_data), 32'h00);
        check_output("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
        check_output("reset_parity_err", 32'(bus.rx_parity_err), 32'd0);
        check_output("reset_frame_err", 32'(bus.rx_frame_err), 32'd0);
        check_output("reset_rx_busy", 32'(bus.rx_busy), 32'd0);
        @(posedge rx_clk);
        #1;
        reset = 1'b0;
        idle_cycles(20);

        $display("[TB] clean frame 0xA5");
        apply_stimulus(8'hA5, 1'b0, 1'b1, -1, 1'b1, n);
        idle_cycles(10);
        busy_ones = 0;
        for (int c = n + 3; c <= n + 170; c++)
            if (busy_hist[c] === 1'b1) busy_ones++;
        check_output("busy_before_D1", 32'(busy_hist[n + 2]), 32'd0);
        check_output("busy_D1_to_D168", 32'(busy_ones), 32'd168);
        check_output("busy_at_valid", 32'(busy_hist[n + 171]), 32'd0);

        $display("[TB] parity error 0x01");
        apply_stimulus(8'h01, 1'b1, 1'b1, -1, 1'b1, n);
        idle_cycles(10);

        $display("[TB] reset during data bit 4 of 0x77");
        apply_stimulus(8'h77, 1'b0, 1'b1, 5, 1'b0, n);
        @(negedge rx_clk);
        check_output("midreset_rx_data", 32'(bus.rx_data), 32'h00);
        check_output("midreset_rx_valid", 32'(bus.rx_valid), 32'd0);
        check_output("midreset_parity_err", 32'(bus.rx_parity_err), 32'd0);
        check_output("midreset_frame_err", 32'(bus.rx_frame_err), 32'd0);
        check_output("midreset_rx_busy", 32'(bus.rx_busy), 32'd0);
        idle_cycles(200);
        apply_stimulus(8'h5A, 1'b0, 1'b1, -1, 1'b1, n);
        idle_cycles(10);

        $display("[TB] framing error then recovery 0x3C");
        apply_stimulus(8'h3C, 1'b0, 1'b0, -1, 1'b1, n);
        idle_cycles(30);
        bus.rx_serial = 1'b1;
        idle_cycles(20);
        apply_stimulus(8'h3C, 1'b0, 1'b1, -1, 1'b1, n);
        idle_cycles(10);

        $display("[TB] glitch then 0x5A");
        n = cyc;
        bus.rx_serial = 1'b0;
        idle_cycles(4);
        bus.rx_serial = 1'b1;
        idle_cycles(30);
        check_output("glitch_busy_D1", 32'(busy_hist[n + 3]), 32'd1);
        check_output("glitch_busy_D9", 32'(busy_hist[n + 11]), 32'd0);
        apply_stimulus(8'h5A, 1'b0, 1'b1, -1, 1'b1, n);
        idle_cycles(10);

        $display("[TB] back-to-back 0x00 then 0xFF");
        apply_stimulus(8'h00, 1'b0, 1'b1, -1, 1'b1, n);
        apply_stimulus(8'hFF, 1'b0, 1'b1, -1, 1'b1, n2);
        idle_cycles(40);
        check_output("b2b_busy_second_D1", 32'(busy_hist[n2 + 3]), 32'd1);

        idle_cycles(20);
        check_output("frames_outstanding", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
